// File: rtl/key_click_decoder.sv
// key_click_decoder: classifies debounced key press pulses as single or
// double clicks using a programmable inter-press window, and keeps an
// 8-bit wrapping count of decoded events.
module key_click_decoder #(
  parameter int unsigned WINDOW = 15000000,
  parameter int unsigned CNT_W  = 24
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       KeyPulse,
  output logic       SingleClick,
  output logic       DoubleClick,
  output logic       Busy,
  output logic [7:0] ClickCnt
);

  typedef enum logic {
    IDLE = 1'b0,
    WAIT = 1'b1
  } state_t;

  // Timer value on the edge that closes the window (edge E_WINDOW).
  localparam logic [CNT_W-1:0] LP_LAST = CNT_W'(WINDOW - 1);

  state_t           r_state;
  logic [CNT_W-1:0] r_timer;
  logic             r_single;
  logic             r_double;
  logic [7:0]       r_cnt;
  logic             w_expire;

  assign w_expire = (r_timer == LP_LAST);

  // Click classification FSM with registered event pulses and event counter.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_state  <= IDLE;
      r_timer  <= '0;
      r_single <= 1'b0;
      r_double <= 1'b0;
      r_cnt    <= 8'd0;
    end else begin
      r_single <= 1'b0;
      r_double <= 1'b0;
      case (r_state)
        IDLE: begin
          if (KeyPulse) begin
            r_state <= WAIT;
            r_timer <= '0;
          end
        end
        WAIT: begin
          // A second press wins over window expiry on the same edge.
          if (KeyPulse) begin
            r_double <= 1'b1;
            r_cnt    <= r_cnt + 8'd1;
            r_state  <= IDLE;
          end else if (w_expire) begin
            r_single <= 1'b1;
            r_cnt    <= r_cnt + 8'd1;
            r_state  <= IDLE;
          end else begin
            r_timer <= r_timer + CNT_W'(1);
          end
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign SingleClick = r_single;
  assign DoubleClick = r_double;
  assign Busy        = (r_state == WAIT);
  assign ClickCnt    = r_cnt;

endmodule

// File: tb/tb_key_click_decoder.sv
// tb_key_click_decoder: scenario tasks drive press patterns and queue the
// expected decode events; a negedge monitor pops and checks each event.
module tb_key_click_decoder;

  localparam int unsigned WINDOW = 8;
  localparam int unsigned CNT_W  = 4;

  logic       CLK;
  logic       RST;
  logic       KeyPulse;
  logic       SingleClick;
  logic       DoubleClick;
  logic       Busy;
  logic [7:0] ClickCnt;

  typedef struct {
    bit          single;
    int unsigned cyc;
    logic [7:0]  cnt;
  } exp_t;

  exp_t        exp_q[$];
  logic [7:0]  exp_cnt;
  int unsigned cyc;
  int          n_tests;
  int          n_fail;

  key_click_decoder #(.WINDOW(WINDOW), .CNT_W(CNT_W)) dut (
    .CLK        (CLK),
    .RST        (RST),
    .KeyPulse   (KeyPulse),
    .SingleClick(SingleClick),
    .DoubleClick(DoubleClick),
    .Busy       (Busy),
    .ClickCnt   (ClickCnt)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Edge counter: at a negedge, cyc equals the number of rising edges so far.
  always @(posedge CLK) cyc <= cyc + 1;

  // Scoreboard monitor: every decode pulse must match the head of the queue.
  always @(negedge CLK) begin
    exp_t e;
    if (!RST && (SingleClick || DoubleClick)) begin
      n_tests++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_event cyc=%0d single=%b double=%b cnt=%0d",
                 cyc, SingleClick, DoubleClick, ClickCnt);
      end else begin
        e = exp_q.pop_front();
        if (SingleClick !== e.single || DoubleClick !== !e.single ||
            cyc !== e.cyc || ClickCnt !== e.cnt) begin
          n_fail++;
          $display("FAIL event got single=%b double=%b cyc=%0d cnt=%0d want single=%b cyc=%0d cnt=%0d",
                   SingleClick, DoubleClick, cyc, ClickCnt, e.single, e.cyc, e.cnt);
        end
      end
    end
  end

  // Present one KeyPulse value to the next rising edge; return at the negedge after it.
  task automatic step(input logic kp);
    KeyPulse = kp;
    @(posedge CLK);
    @(negedge CLK);
    KeyPulse = 1'b0;
  endtask

  task automatic push_exp(input bit single, input int unsigned at);
    exp_t e;
    exp_cnt  = exp_cnt + 8'd1;
    e.single = single;
    e.cyc    = at;
    e.cnt    = exp_cnt;
    exp_q.push_back(e);
  endtask

  task automatic test_reset();
    RST      = 1'b1;
    KeyPulse = 1'b0;
    exp_cnt  = 8'd0;
    #3;
    n_tests++;
    if ({SingleClick, DoubleClick, Busy, ClickCnt} !== 11'd0) begin
      n_fail++;
      $display("FAIL reset_values got %b want 0", {SingleClick, DoubleClick, Busy, ClickCnt});
    end
    repeat (3) @(posedge CLK);
    @(negedge CLK);
    RST = 1'b0;
    for (int i = 0; i < 12; i++) begin
      step(1'b0);
      n_tests++;
      if ({SingleClick, DoubleClick, Busy, ClickCnt} !== 11'd0) begin
        n_fail++;
        $display("FAIL reset_quiet i=%0d got %b want 0", i, {SingleClick, DoubleClick, Busy, ClickCnt});
      end
    end
  endtask

  task automatic test_single();
    int unsigned c0;
    step(1'b1);
    c0 = cyc;
    push_exp(1'b1, c0 + WINDOW);
    n_tests++;
    if (Busy !== 1'b1) begin
      n_fail++;
      $display("FAIL single_busy_e0 got %b want 1", Busy);
    end
    for (int k = 1; k <= 8; k++) begin
      step(1'b0);
      n_tests++;
      if (Busy !== (k < 8)) begin
        n_fail++;
        $display("FAIL single_busy k=%0d got %b want %b", k, Busy, (k < 8));
      end
    end
    repeat (4) step(1'b0);
    n_tests++;
    if (exp_q.size() != 0 || ClickCnt !== exp_cnt) begin
      n_fail++;
      $display("FAIL single_done pending=%0d cnt=%0d want pending=0 cnt=%0d", exp_q.size(), ClickCnt, exp_cnt);
    end
  endtask

  task automatic test_double();
    int unsigned c0;
    step(1'b1);
    c0 = cyc;
    push_exp(1'b0, c0 + 3);
    step(1'b0);
    step(1'b0);
    step(1'b1);
    n_tests++;
    if (Busy !== 1'b0) begin
      n_fail++;
      $display("FAIL double_busy got %b want 0", Busy);
    end
    repeat (12) step(1'b0);
    n_tests++;
    if (exp_q.size() != 0 || ClickCnt !== exp_cnt) begin
      n_fail++;
      $display("FAIL double_done pending=%0d cnt=%0d want pending=0 cnt=%0d", exp_q.size(), ClickCnt, exp_cnt);
    end
  endtask

  task automatic test_window_boundary();
    int unsigned c0;
    // Second press exactly on E_WINDOW still counts as a double click.
    step(1'b1);
    c0 = cyc;
    push_exp(1'b0, c0 + WINDOW);
    repeat (7) step(1'b0);
    step(1'b1);
    repeat (12) step(1'b0);
    n_tests++;
    if (exp_q.size() != 0 || ClickCnt !== exp_cnt) begin
      n_fail++;
      $display("FAIL boundary_e8 pending=%0d cnt=%0d want pending=0 cnt=%0d", exp_q.size(), ClickCnt, exp_cnt);
    end
    // Press on E_WINDOW+1 follows a single decode and opens a new window.
    step(1'b1);
    c0 = cyc;
    push_exp(1'b1, c0 + WINDOW);
    push_exp(1'b1, c0 + 2 * WINDOW + 1);
    repeat (8) step(1'b0);
    step(1'b1);
    n_tests++;
    if (Busy !== 1'b1) begin
      n_fail++;
      $display("FAIL boundary_e9_busy got %b want 1", Busy);
    end
    repeat (12) step(1'b0);
    n_tests++;
    if (exp_q.size() != 0 || ClickCnt !== exp_cnt) begin
      n_fail++;
      $display("FAIL boundary_e9 pending=%0d cnt=%0d want pending=0 cnt=%0d", exp_q.size(), ClickCnt, exp_cnt);
    end
  endtask

  task automatic test_triple();
    int unsigned c0;
    step(1'b1);
    c0 = cyc;
    push_exp(1'b0, c0 + 2);
    push_exp(1'b1, c0 + 12);
    step(1'b0);
    step(1'b1);
    step(1'b0);
    step(1'b1);
    repeat (14) step(1'b0);
    n_tests++;
    if (exp_q.size() != 0 || ClickCnt !== exp_cnt) begin
      n_fail++;
      $display("FAIL triple_done pending=%0d cnt=%0d want pending=0 cnt=%0d", exp_q.size(), ClickCnt, exp_cnt);
    end
  endtask

  task automatic test_reset_mid_wait();
    step(1'b1);
    repeat (4) step(1'b0);
    #2;
    RST = 1'b1;
    #1;
    n_tests++;
    if ({SingleClick, DoubleClick, Busy, ClickCnt} !== 11'd0) begin
      n_fail++;
      $display("FAIL async_reset got %b want 0", {SingleClick, DoubleClick, Busy, ClickCnt});
    end
    exp_cnt = 8'd0;
    @(negedge CLK);
    RST = 1'b0;
    for (int i = 0; i < 15; i++) begin
      step(1'b0);
      n_tests++;
      if (Busy !== 1'b0 || ClickCnt !== 8'd0) begin
        n_fail++;
        $display("FAIL post_reset i=%0d busy=%b cnt=%0d want busy=0 cnt=0", i, Busy, ClickCnt);
      end
    end
  endtask

  task automatic test_wrap();
    for (int n = 1; n <= 257; n++) begin
      step(1'b1);
      push_exp(1'b1, cyc + WINDOW);
      repeat (8) step(1'b0);
      if (n == 256) begin
        n_tests++;
        if (ClickCnt !== 8'd0) begin
          n_fail++;
          $display("FAIL wrap_256 got %0d want 0", ClickCnt);
        end
      end
    end
    n_tests++;
    if (ClickCnt !== 8'd1) begin
      n_fail++;
      $display("FAIL wrap_257 got %0d want 1", ClickCnt);
    end
    repeat (4) step(1'b0);
    n_tests++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL wrap_pending got %0d want 0", exp_q.size());
    end
  endtask

  initial begin
    n_tests  = 0;
    n_fail   = 0;
    cyc      = 0;
    exp_cnt  = 8'd0;
    KeyPulse = 1'b0;
    RST      = 1'b1;
    test_reset();
    test_single();
    test_double();
    test_window_boundary();
    test_triple();
    test_reset_mid_wait();
    test_wrap();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/key_click_decoder.md
# key_click_decoder

Downstream stage of the key debouncer. Consumes its one-cycle press pulses and classifies each press burst as a single click or a double click, using a programmable inter-press window. It emits a one-cycle event pulse per classification and keeps a running 8-bit event count. Menu and mode logic use it to map a single physical key to two commands.

## Interface
- WINDOW, default 15000000: double-click window in CLK cycles (300 ms at 50 MHz). Legal range ≥ 2.
- CNT_W, default 24: width of the window timer. Must satisfy 2^CNT_W > WINDOW − 1.

- CLK  input  1  system clock; all state changes on the rising edge.
- RST  input  1  reset, asynchronous, active-high.
- KeyPulse  input  1  debounced press pulse from the debouncer. Each cycle sampled high counts as one press.
- SingleClick  output  1  one-cycle pulse: a single click was decoded.
- DoubleClick  output  1  one-cycle pulse: a double click was decoded.
- Busy  output  1  high while a first press is waiting for a possible second press.
- ClickCnt  output  8  count of decoded events (single plus double); wraps modulo 256.

## Operation
- State machine has two states:
  - IDLE: no press pending.
  - WAIT: a first press has been taken and the window is running.
- IDLE:
  - KeyPulse=1 at an edge: go to WAIT and set timer to 0.
  - Otherwise: hold state.
- WAIT, evaluated at each edge in priority order:
  - KeyPulse=1: DoubleClick<=1, ClickCnt<=ClickCnt+1, go to IDLE. This branch wins even if the timer is at expiry on the same edge.
  - Else, timer==WINDOW−1: SingleClick<=1, ClickCnt<=ClickCnt+1, go to IDLE.
  - Else: timer<=timer+1.
- A press that arrives in IDLE on the edge right after a decode starts a new sequence. Example: the third press of a triple burst opens a fresh WAIT.
- A KeyPulse held high for two or more cycles is treated as repeated presses. The debouncer guarantees single-cycle pulses.
- SingleClick and DoubleClick are registered, never high together, and de-assert on the following edge.
- ClickCnt is unsigned 8-bit and wraps 255 → 0 with no flag.
- Busy is high exactly when state==WAIT.

## Timing
- Reset values:
  - state IDLE, timer 0.
  - SingleClick 0, DoubleClick 0, Busy 0, ClickCnt 0.
- Reset during WAIT discards the pending press. No event is emitted after reset releases.
- Edge numbering: E0 is the edge that samples the first press. Busy is high from after E0 until after the decode edge.
- Double click: a second press sampled at edge Ek, with 1 ≤ k ≤ WINDOW, gives DoubleClick high for the one cycle after Ek.
- Single click: with no press at E1..E_WINDOW, SingleClick is high for the one cycle after E_WINDOW. Latency from the first press is WINDOW cycles.
- A press sampled at E_(WINDOW+1) falls after a single decode. It starts a new WAIT on that edge.
- The block accepts a new first press on any edge where it is in IDLE, including the edge immediately after a decode pulse.

## Test plan
Run with WINDOW=8, CNT_W=4.

- Reset check: assert RST asynchronously mid-cycle → all outputs 0 immediately; hold 3 cycles; after release, no output activity without KeyPulse.
- Single click: pulse at E0 only → Busy high E0..E8; SingleClick high for one cycle after E8; DoubleClick never high; ClickCnt=1.
- Double click: pulses at E0 and E3 → DoubleClick high one cycle after E3; Busy low after E3; no SingleClick; ClickCnt=1.
- Window boundary: pulses at E0 and E8 → DoubleClick after E8, no SingleClick. Separate run with pulses at E0 and E9 → SingleClick after E8, then Busy high again from E9, then SingleClick after E17; ClickCnt=2.
- Triple burst: pulses at E0, E2, E4 → DoubleClick after E2, SingleClick after E12; ClickCnt=2.
- Reset mid-WAIT and wrap:
  - Pulse at E0, RST pulse between E4 and E5 → no SingleClick ever, Busy 0, ClickCnt 0.
  - Then 256 single clicks → ClickCnt reads 0 after the 256th and 1 after the 257th.
